ws_pe_db: RTL and testbench

Parametrised weight-stationary processing element for the systolic array, intended as the successor to the single-weight PE. Adds several capabilities:
- independent data, weight and partial-sum widths;
- a double-buffered weight (shadow + active) so the next tile's weights shift in while the current tile computes;
- valid tagging of the data/psum wavefront;
- optional saturating accumulation with a sticky overflow flag.

One instance sits at each array node. Data flows horizontally; weights and partial sums flow vertically.

---
 rtl/pe_pkg.sv | 22 ++
 rtl/mac_sat.sv | 39 +++
 rtl/ws_pe_db.sv | 94 +++++++++
 tb/tb_ws_pe_db.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// Shared definitions for the systolic-array processing elements:
// mode encodings and signed saturation bounds.
package pe_pkg;

    localparam logic [1:0] MODE_IDLE       = 2'b00;
    localparam logic [1:0] MODE_WLOAD      = 2'b01;
    localparam logic [1:0] MODE_COMP       = 2'b10;
    localparam logic [1:0] MODE_COMP_WLOAD = 2'b11;

    localparam int SAT_W = 64;

    // Largest signed value representable in w bits, zero-extended to SAT_W.
    function automatic logic [SAT_W-1:0] sat_max(input int w);
        sat_max = (64'd1 << (w - 1)) - 64'd1;
    endfunction

    // Most negative signed value in w bits; low w bits are 100..0.
    function automatic logic [SAT_W-1:0] sat_min(input int w);
        sat_min = ~sat_max(w);
    endfunction

endpackage

// File: rtl/mac_sat.sv
// Combinational signed multiply-accumulate with overflow detect and
// optional clamp to the partial-sum range.
module mac_sat
    import pe_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int WEIGHT_WIDTH = 8,
    parameter int PSUM_WIDTH   = 24,
    parameter bit SATURATE     = 1'b1
) (
    input  logic [DATA_WIDTH-1:0]   data,
    input  logic [WEIGHT_WIDTH-1:0] weight,
    input  logic [PSUM_WIDTH-1:0]   psum,
    output logic [PSUM_WIDTH-1:0]   result,
    output logic                    ovf
);

    localparam int PROD_W = DATA_WIDTH + WEIGHT_WIDTH;
    localparam int EXT_W  = PSUM_WIDTH + 1 - PROD_W;

    localparam logic [PSUM_WIDTH-1:0] PMAX = PSUM_WIDTH'(sat_max(PSUM_WIDTH));
    localparam logic [PSUM_WIDTH-1:0] PMIN = PSUM_WIDTH'(sat_min(PSUM_WIDTH));

    logic signed [PROD_W-1:0] prod;
    logic [PSUM_WIDTH:0]      sum;

    // Full-precision product, then one guard bit above the psum range so
    // overflow shows up as disagreement of the top two sum bits.
    always_comb begin
        prod   = $signed(data) * $signed(weight);
        sum    = {{EXT_W{prod[PROD_W-1]}}, prod} + {psum[PSUM_WIDTH-1], psum};
        ovf    = sum[PSUM_WIDTH] ^ sum[PSUM_WIDTH-1];
        result = sum[PSUM_WIDTH-1:0];
        if (SATURATE && ovf) begin
            result = sum[PSUM_WIDTH] ? PMIN : PMAX;
        end
    end

endmodule

// File: rtl/ws_pe_db.sv
// Weight-stationary PE with double-buffered weight: the shadow register
// forms the vertical weight chain while the active register feeds the MAC.
module ws_pe_db
    import pe_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int WEIGHT_WIDTH = 8,
    parameter int PSUM_WIDTH   = 24,
    parameter bit SATURATE     = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [1:0]              mode_ctrl,
    input  logic                    weight_swap,
    input  logic [DATA_WIDTH-1:0]   data_in,
    input  logic                    data_valid_in,
    input  logic [WEIGHT_WIDTH-1:0] weight_in,
    input  logic [PSUM_WIDTH-1:0]   psum_in,
    input  logic                    flag_clr,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    data_valid_out,
    output logic [WEIGHT_WIDTH-1:0] weight_out,
    output logic [PSUM_WIDTH-1:0]   psum_out,
    output logic                    sat_flag
);

    logic [WEIGHT_WIDTH-1:0] shadow_q, shadow_d;
    logic [WEIGHT_WIDTH-1:0] active_q, active_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    dvld_q, dvld_d;
    logic [PSUM_WIDTH-1:0]   psum_q, psum_d;
    logic                    sat_q, sat_d;

    logic                    wload, comp, mac_en;
    logic [PSUM_WIDTH-1:0]   mac_res;
    logic                    mac_ovf;

    // MAC always sees the active weight as it stood before this edge, so a
    // swap only takes effect for the following cycle.
    mac_sat #(
        .DATA_WIDTH   (DATA_WIDTH),
        .WEIGHT_WIDTH (WEIGHT_WIDTH),
        .PSUM_WIDTH   (PSUM_WIDTH),
        .SATURATE     (SATURATE)
    ) u_mac (
        .data   (data_in),
        .weight (active_q),
        .psum   (psum_in),
        .result (mac_res),
        .ovf    (mac_ovf)
    );

    // Next-state for every register from mode, swap and MAC result.
    always_comb begin
        wload  = (mode_ctrl == MODE_WLOAD) || (mode_ctrl == MODE_COMP_WLOAD);
        comp   = (mode_ctrl == MODE_COMP)  || (mode_ctrl == MODE_COMP_WLOAD);
        mac_en = comp && data_valid_in;

        shadow_d = wload ? weight_in : shadow_q;
        // Reads the pre-edge shadow, so load+swap moves the old shadow up.
        active_d = weight_swap ? shadow_q : active_q;
        data_d   = comp ? data_in : data_q;
        dvld_d   = mac_en;
        psum_d   = mac_en ? mac_res : psum_q;
        // Set has priority over clear.
        sat_d    = (mac_en && mac_ovf) || (sat_q && !flag_clr);
    end

    // State registers, all cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= '0;
            active_q <= '0;
            data_q   <= '0;
            dvld_q   <= 1'b0;
            psum_q   <= '0;
            sat_q    <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
            data_q   <= data_d;
            dvld_q   <= dvld_d;
            psum_q   <= psum_d;
            sat_q    <= sat_d;
        end
    end

    assign data_out       = data_q;
    assign data_valid_out = dvld_q;
    assign weight_out     = shadow_q;
    assign psum_out       = psum_q;
    assign sat_flag       = sat_q;

endmodule

// File: tb/tb_ws_pe_db.sv
// Bench for ws_pe_db: two 16-bit-psum instances (saturating and wrapping)
// share stimulus; an integer-arithmetic model predicts every output.
module tb_ws_pe_db;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  mode_ctrl = 2'b00;
    logic        weight_swap = 1'b0;
    logic [7:0]  data_in = '0;
    logic        data_valid_in = 1'b0;
    logic [7:0]  weight_in = '0;
    logic [15:0] psum_in = '0;
    logic        flag_clr = 1'b0;

    logic [7:0]  dout_s, dout_w, wout_s, wout_w;
    logic        dvo_s, dvo_w, flag_s, flag_w;
    logic [15:0] psum_s, psum_w;

    int n_cmp = 0;
    int n_err = 0;

    // model state (signed integer values)
    int m_shadow, m_active, m_dout, m_dvo;
    int m_psum[2];
    int m_flag[2];

    always #5 clk = ~clk;

    ws_pe_db #(.DATA_WIDTH(8), .WEIGHT_WIDTH(8), .PSUM_WIDTH(16), .SATURATE(1'b1)) u_sat (
        .clk(clk), .rst_n(rst_n), .mode_ctrl(mode_ctrl), .weight_swap(weight_swap),
        .data_in(data_in), .data_valid_in(data_valid_in), .weight_in(weight_in),
        .psum_in(psum_in), .flag_clr(flag_clr), .data_out(dout_s),
        .data_valid_out(dvo_s), .weight_out(wout_s), .psum_out(psum_s), .sat_flag(flag_s)
    );

    ws_pe_db #(.DATA_WIDTH(8), .WEIGHT_WIDTH(8), .PSUM_WIDTH(16), .SATURATE(1'b0)) u_wrap (
        .clk(clk), .rst_n(rst_n), .mode_ctrl(mode_ctrl), .weight_swap(weight_swap),
        .data_in(data_in), .data_valid_in(data_valid_in), .weight_in(weight_in),
        .psum_in(psum_in), .flag_clr(flag_clr), .data_out(dout_w),
        .data_valid_out(dvo_w), .weight_out(wout_w), .psum_out(psum_w), .sat_flag(flag_w)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_shadow = 0; m_active = 0; m_dout = 0; m_dvo = 0;
        m_psum[0] = 0; m_psum[1] = 0; m_flag[0] = 0; m_flag[1] = 0;
    endtask

    // Apply the rules of one clock edge to the model using current inputs.
    task automatic model_edge();
        int d, w, p, sum, res_sat, res_wrap;
        bit ovf, comp, load;
        d    = int'($signed(data_in));
        w    = int'($signed(weight_in));
        p    = int'($signed(psum_in));
        comp = mode_ctrl[1];
        load = mode_ctrl[0];
        sum  = p + d * m_active;
        ovf  = (sum > 32767) || (sum < -32768);
        res_sat  = (sum > 32767) ? 32767 : (sum < -32768) ? -32768 : sum;
        res_wrap = (sum > 32767) ? sum - 65536 : (sum < -32768) ? sum + 65536 : sum;
        for (int k = 0; k < 2; k++) begin
            if (!(comp && data_valid_in && ovf) && flag_clr) m_flag[k] = 0;
            if (comp && data_valid_in && ovf) m_flag[k] = 1;
        end
        if (comp && data_valid_in) begin
            m_psum[0] = res_sat;
            m_psum[1] = res_wrap;
        end
        if (comp) m_dout = d;
        m_dvo = (comp && data_valid_in) ? 1 : 0;
        if (weight_swap) m_active = m_shadow;
        if (load) m_shadow = w;
    endtask

    task automatic check_all();
        chk("data_out_s",  int'($signed(dout_s)), m_dout);
        chk("data_out_w",  int'($signed(dout_w)), m_dout);
        chk("dvalid_s",    int'(dvo_s), m_dvo);
        chk("dvalid_w",    int'(dvo_w), m_dvo);
        chk("weight_out_s", int'($signed(wout_s)), m_shadow);
        chk("weight_out_w", int'($signed(wout_w)), m_shadow);
        chk("psum_sat",    int'($signed(psum_s)), m_psum[0]);
        chk("psum_wrap",   int'($signed(psum_w)), m_psum[1]);
        chk("flag_sat",    int'(flag_s), m_flag[0]);
        chk("flag_wrap",   int'(flag_w), m_flag[1]);
    endtask

    task automatic step(input logic [1:0] m, input logic sw, input int d, input logic dv,
                        input int w, input int p, input logic clr);
        @(negedge clk);
        mode_ctrl     = m;
        weight_swap   = sw;
        data_in       = 8'(d);
        data_valid_in = dv;
        weight_in     = 8'(w);
        psum_in       = 16'(p);
        flag_clr      = clr;
        @(posedge clk);
        model_edge();
        #1 check_all();
    endtask

    initial begin
        model_clear();
        // reset state with inputs busy
        mode_ctrl = 2'b11; weight_swap = 1'b1; data_in = 8'h55; data_valid_in = 1'b1;
        weight_in = 8'h33; psum_in = 16'h1234;
        repeat (2) @(posedge clk);
        #1 check_all();
        @(negedge clk);
        rst_n = 1'b1;
        mode_ctrl = 2'b00; weight_swap = 1'b0; data_valid_in = 1'b0;

        // basic MAC: weight -4, 3*-4+10 = -2
        step(2'b01, 1'b0, 0, 1'b0, -4, 0, 1'b0);
        step(2'b00, 1'b1, 0, 1'b0, 0, 0, 1'b0);
        step(2'b10, 1'b0, 3, 1'b1, 0, 10, 1'b0);
        chk("basic_psum", int'($signed(psum_s)), -2);
        chk("basic_dout", int'($signed(dout_s)), 3);
        chk("basic_flag", int'(flag_s), 0);

        // valid gating: psum holds, valid low; idle forces valid low
        step(2'b10, 1'b0, 9, 1'b0, 0, 100, 1'b0);
        chk("gate_psum_hold", int'($signed(psum_s)), -2);
        chk("gate_dvo", int'(dvo_s), 0);
        step(2'b00, 1'b0, 7, 1'b1, 0, 100, 1'b0);
        chk("idle_dvo", int'(dvo_s), 0);
        chk("idle_dout_hold", int'($signed(dout_s)), 9);

        // saturation / wrap: 127*127 + 32767 = 48896
        step(2'b01, 1'b0, 0, 1'b0, 127, 0, 1'b0);
        step(2'b00, 1'b1, 0, 1'b0, 0, 0, 1'b0);
        step(2'b10, 1'b0, 127, 1'b1, 0, 32767, 1'b0);
        chk("sat_psum", int'($signed(psum_s)), 32767);
        chk("wrap_psum", int'($signed(psum_w)), -16640);
        chk("sat_flag_set", int'(flag_s), 1);
        chk("wrap_flag_set", int'(flag_w), 1);
        step(2'b10, 1'b0, 1, 1'b1, 0, 5, 1'b0);
        chk("flag_sticky", int'(flag_s), 1);
        // set wins over clear
        step(2'b10, 1'b0, -128, 1'b1, 0, -32768, 1'b1);
        chk("flag_set_wins", int'(flag_s), 1);
        step(2'b00, 1'b0, 0, 1'b0, 0, 0, 1'b1);
        chk("flag_cleared", int'(flag_s), 0);

        // concurrent load/swap: active=2, shadow=5, then mode 11 with 7
        step(2'b01, 1'b0, 0, 1'b0, 2, 0, 1'b0);
        step(2'b01, 1'b1, 0, 1'b0, 5, 0, 1'b0);
        step(2'b11, 1'b1, 1, 1'b1, 7, 0, 1'b0);
        chk("cls_old_active", int'($signed(psum_s)), 2);
        step(2'b10, 1'b0, 1, 1'b1, 0, 0, 1'b0);
        chk("cls_new_active", int'($signed(psum_s)), 5);
        chk("cls_weight_out", int'($signed(wout_s)), 7);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0),
                 int'($urandom_range(0, 255)) - 128, 1'($urandom),
                 int'($urandom_range(0, 255)) - 128,
                 int'($urandom_range(0, 65535)) - 32768,
                 ($urandom_range(0, 7) == 0));
        end

        // mid-compute reset clears immediately; first compute uses weight 0
        step(2'b01, 1'b0, 0, 1'b0, 9, 0, 1'b0);
        step(2'b10, 1'b1, 4, 1'b1, 0, 77, 1'b0);
        @(posedge clk);
        model_edge();
        #2 rst_n = 1'b0;
        #1;
        model_clear();
        check_all();
        chk("rst_psum", int'($signed(psum_s)), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step(2'b10, 1'b0, 5, 1'b1, 0, 123, 1'b0);
        chk("post_rst_w0", int'($signed(psum_s)), 123);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
